// File: rtl/frame_gen_pkg.sv
// Shared encodings for axis_frame_gen: payload modes, FSM states and PN LFSR constants.
package frame_gen_pkg;

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_PN    = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StPad,
        StGap
    } state_e;

    // x^15 + x^14 + 1, shifting towards the MSB; the MSB is the output bit.
    localparam logic [14:0]  LFSR_SEED   = 15'h7FFF;
    localparam int unsigned  LFSR_TAP_HI = 14;
    localparam int unsigned  LFSR_TAP_LO = 13;

    function automatic logic [14:0] lfsr_next(input logic [14:0] s);
        return {s[13:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/pn_lfsr.sv
// 15-bit Fibonacci PN generator with step enable and synchronous reseed to LFSR_SEED.
module pn_lfsr
    import frame_gen_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        step,
    input  logic        reseed,
    output logic [14:0] state,
    output logic        pn_bit
);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= LFSR_SEED;
        end else if (reseed) begin
            state <= LFSR_SEED;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

    assign pn_bit = state[LFSR_TAP_HI];

endmodule

// File: rtl/axis_frame_gen.sv
// Framed AXI4-Stream test-signal source: ramp/constant/PN payload, zero pad, tlast, idle gap.
// Define FRAME_GEN_PN_EN to build the PN payload mode; without it mode 2 falls back to ramp.
module axis_frame_gen
    import frame_gen_pkg::*;
#(
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       FRAME_LEN  = 40,
    parameter int unsigned       ACTIVE_LEN = 32,
    parameter int unsigned       GAP_LEN    = 0,
    parameter logic [DATA_W-1:0] CONST_VAL  = 16'h4000,
    parameter logic [DATA_W-1:0] PN_AMP     = 16'h3FFF
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [15:0]       num_frames,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned       BEAT_W     = $clog2(FRAME_LEN + 1);
    localparam int unsigned       GAP_W      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [BEAT_W-1:0] ACTIVE_END = BEAT_W'(ACTIVE_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_LEN - 1);
    localparam logic              FIRST_LAST = (FRAME_LEN == 1);

    if (FRAME_LEN < 1 || ACTIVE_LEN < 1 || ACTIVE_LEN > FRAME_LEN || PN_AMP[DATA_W-1])
    begin : g_param_check
        $error("axis_frame_gen: illegal FRAME_LEN/ACTIVE_LEN/PN_AMP");
    end

    state_e            state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_nxt;
    logic [BEAT_W-1:0] idx;
    logic [GAP_W-1:0]  gap_q;
    logic [1:0]        mode_q;
    logic [1:0]        mode_sel;
    logic              stop_q;
    logic              handshake;
    logic              burst_end;
    logic [15:0]       cnt_inc;
    logic [DATA_W-1:0] payload_nxt;

    assign handshake = m_axis_tvalid && m_axis_tready;
    assign beat_nxt  = beat_q + 1'b1;
    assign cnt_inc   = frame_cnt + 16'd1;
    assign burst_end = stop_q || stop || (num_frames != 16'd0 && cnt_inc == num_frames);
    assign busy      = (state_q != StIdle);

`ifdef FRAME_GEN_PN_EN
    logic [14:0] lfsr_state;
    logic        lfsr_bit;

    pn_lfsr u_pn_lfsr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .step    (handshake && state_q == StActive),
        .reseed  (handshake && m_axis_tlast),
        .state   (lfsr_state),
        .pn_bit  (lfsr_bit)
    );
`endif

    // Payload of the beat that will be loaded at the next advance; beat 0 always starts
    // from a freshly seeded LFSR, later beats see the LFSR after this beat's step.
    always_comb begin
        idx         = (state_q == StIdle || state_q == StGap || m_axis_tlast) ? '0 : beat_nxt;
        mode_sel    = (state_q == StIdle) ? mode : mode_q;
        payload_nxt = DATA_W'(idx);
        if (mode_sel == MODE_CONST) begin
            payload_nxt = CONST_VAL;
        end
`ifdef FRAME_GEN_PN_EN
        if (mode_sel == MODE_PN) begin
            payload_nxt = ((idx == '0) ? LFSR_SEED[LFSR_TAP_HI] : lfsr_state[LFSR_TAP_LO])
                        ? PN_AMP : -PN_AMP;
        end
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            beat_q        <= '0;
            gap_q         <= '0;
            mode_q        <= MODE_RAMP;
            stop_q        <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_done    <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q       <= StActive;
                        beat_q        <= '0;
                        frame_cnt     <= '0;
                        mode_q        <= mode;
                        stop_q        <= stop;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= payload_nxt;
                        m_axis_tlast  <= FIRST_LAST;
                    end
                end
                StGap: begin
                    stop_q <= stop_q | stop;
                    if (gap_q == GAP_LAST) begin
                        state_q       <= StActive;
                        gap_q         <= '0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= payload_nxt;
                        m_axis_tlast  <= FIRST_LAST;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    if (stop) begin
                        stop_q <= 1'b1;
                    end
                    if (handshake && m_axis_tlast) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= cnt_inc;
                        beat_q     <= '0;
                        stop_q     <= 1'b0;
                        if (burst_end) begin
                            state_q       <= StIdle;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tdata  <= '0;
                            m_axis_tlast  <= 1'b0;
                        end else if (GAP_LEN != 0) begin
                            state_q       <= StGap;
                            gap_q         <= '0;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tdata  <= '0;
                            m_axis_tlast  <= 1'b0;
                        end else begin
                            state_q      <= StActive;
                            m_axis_tdata <= payload_nxt;
                            m_axis_tlast <= FIRST_LAST;
                        end
                    end else if (handshake) begin
                        beat_q       <= beat_nxt;
                        state_q      <= (beat_nxt < ACTIVE_END) ? StActive : StPad;
                        m_axis_tdata <= (beat_nxt < ACTIVE_END) ? payload_nxt : '0;
                        m_axis_tlast <= (beat_nxt == LAST_BEAT);
                    end
                end
            endcase
        end
    end

endmodule
